multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the MIPS datapath (PC, IR, regfile, ALU, ALU control, shared memory) over 3-5 cycles per instruction, replacing the single-cycle control decode.
- Drives per-state datapath strobes from the IR opcode.
- Waits on a memory ready handshake and flags a bus error on memory timeout.

Parameters:
- TIMEOUT, 16, max cycles waiting on mem_ready in any memory state; 0 disables the timeout.
- CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]
- mem_ready  in  1  memory has completed the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero_flag
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- mem_to_reg  out  1  writeback select: 0=ALUOut, 1=MDR
- reg_dst  out  1  write register select: 0=rt, 1=rd
- reg_write  out  1  regfile write enable
- alu_src_a  out  1  ALU A select: 0=PC, 1=A reg
- alu_src_b  out  2  ALU B select: 00=B reg, 01=4, 10=sign-extended imm, 11=sign-extended imm<<2
- alu_op  out  2  to ALU control: 00=add, 01=sub, 10=funct
- pc_source  out  2  next-PC select: 00=ALU result, 01=ALUOut, 10=jump target
- state  out  4  current state, for debug
- bus_error  out  1  sticky memory-timeout flag

Behaviour:
- Only the state register, wait counter and bus_error are registered; all strobes decode combinationally from state and mem_ready.
- Reset (rst_n=0, asynchronous): state=FETCH(0), counter=0, bus_error=0, all strobes forced 0. The first active edge after release executes FETCH.
- Strobes not listed for a state are 0.
- State encoding and transitions:
  - FETCH(0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write=pc_write=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00 (branch target to ALUOut). Next state by opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXEC
    - 000100 (beq) -> BRANCH
    - 000010 (j) -> JUMP
    - anything else -> FETCH (treated as NOP)
  - MEMADR(2): alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD for lw, MEMWR for sw.
  - MEMRD(3): mem_read=1, i_or_d=1. Goes to MEMWB on mem_ready.
  - MEMWB(4): reg_write=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
  - MEMWR(5): mem_write=1, i_or_d=1. Goes to FETCH on mem_ready.
  - EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=10. Goes to ALUWB.
  - ALUWB(7): reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Goes to FETCH.
  - JUMP(9): pc_write=1, pc_source=10. Goes to FETCH.
  - ERROR(15): all strobes 0; held until reset.
- Latency in cycles, assuming mem_ready is already high:
  - lw 5
  - sw 4
  - R-type 4
  - beq 3
  - j 3
  - unknown opcode 2
- Wait counter:
  - Increments each cycle spent in FETCH/MEMRD/MEMWR with mem_ready=0.
  - Clears on any state change or when mem_ready=1.
  - If TIMEOUT!=0, mem_ready=0 and counter==TIMEOUT-1: next state is ERROR and bus_error is set.
  - mem_ready=1 in that same cycle takes priority: normal advance, no error.
- opcode is sampled only in DECODE and MEMADR. The IR must hold it stable from the FETCH ir_write until the instruction completes.
- mem_read and mem_write are never high together. Write strobes (reg_write, mem_write, pc_write, ir_write) are at most one cycle per handshake.

Optional Feature:
- Macro: MULTICYCLE_ADDI_EN
- Defined: adds opcode 001000 (addi). DECODE goes to ADDIEX(10): alu_src_a=1, alu_src_b=10, alu_op=00. ADDIEX goes to ADDIWB(11): reg_write=1, reg_dst=0, mem_to_reg=0. ADDIWB goes to FETCH. addi latency 4.
- Undefined: 001000 is an unknown opcode (DECODE goes to FETCH); states 10/11 are unreachable and not implemented.

Test Plan:
- Reset mid-MEMRD (rst_n low for 1 cycle): state=0 and all strobes 0 immediately; bus_error=0; FETCH runs on the next edge after release.
- lw (opcode 100011), mem_ready tied 1: states 0,1,2,3,4; reg_write=1 with mem_to_reg=1 only in state 4; 5 cycles, back to state 0.
- sw with mem_ready low for 3 cycles in MEMWR: mem_write held 4 cycles; exits to FETCH on the ready cycle; bus_error=0.
- beq (000100): state 8 drives pc_write_cond=1, alu_op=01, pc_source=01; j (000010): state 9 drives pc_write=1, pc_source=10; both return to FETCH.
- TIMEOUT=16, mem_ready=0 in FETCH: 16 waiting cycles, then state=15 and bus_error=1; asserting mem_ready afterwards has no effect until rst_n=0.
- Opcode 001000: with MULTICYCLE_ADDI_EN, states 0,1,10,11 with reg_write at 11; without it, states 0,1,0 with no reg_write.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// with a mem_ready handshake and a sticky bus-error timeout. Define MULTICYCLE_ADDI_EN to add addi.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       bus_error
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
`ifdef MULTICYCLE_ADDI_EN
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
`endif
        S_ERROR  = 4'd15
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MULTICYCLE_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFS = 2'b11;
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] PCS_ALU   = 2'b00;
    localparam logic [1:0] PCS_OUT   = 2'b01;
    localparam logic [1:0] PCS_JUMP  = 2'b10;

    // CNT_W must satisfy 2**CNT_W > TIMEOUT so the last wait value is representable.
    localparam bit              TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_EN ? TIMEOUT - 1 : 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_error_q;
    logic             waiting;
    logic             timeout_hit;
    ctrl_t            ctrl;

    assign waiting = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                     && !mem_ready;
    assign timeout_hit = TIMEOUT_EN && waiting && (cnt_q == CNT_LAST);

    // NOTE: every signal written here gets a default first, so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        ctrl    = '0;

        unique case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCS_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_BOFS;
                ctrl.alu_op    = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                if (opcode == OP_LW)      state_d = S_MEMRD;
                else if (opcode == OP_SW) state_d = S_MEMWR;
                else                      state_d = S_FETCH;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
                state_d        = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                state_d        = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCS_OUT;
                state_d            = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCS_JUMP;
                state_d        = S_FETCH;
            end
`ifdef MULTICYCLE_ADDI_EN
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                state_d        = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
                state_d        = S_FETCH;
            end
`endif
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_FETCH;
        endcase

        // A ready memory in the final wait cycle wins over the timeout.
        if (timeout_hit) state_d = S_ERROR;

        // Strobes must be quiet for the whole reset window, not only after the edge.
        if (!rst_n) ctrl = '0;
    end

    assign cnt_d = (waiting && (state_d == state_q)) ? cnt_q + 1'b1 : '0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            cnt_q       <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (timeout_hit) bus_error_q <= 1'b1;
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign state         = state_q;
    assign bus_error     = bus_error_q;

    a_rd_wr_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_read && mem_write));
    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
        !TIMEOUT_EN || (32'(cnt_q) < TIMEOUT));

endmodule
